md_sched: RTL and testbench

- Scheduler and owner of the multi-cycle multiply/divide resource and its HI/LO registers.
- Sits beside the ALU in the E stage.
- Accepts mult/div/mthi/mtlo issued from E and sequences the fixed-latency busy window.
- Produces the stall request the hazard logic ORs into the global stall.
- Provides mfhi/mflo read data to E.

---
 rtl/md_defs.sv | 33 +++
 rtl/md_sched_if.sv | 26 ++
 rtl/md_arith.sv | 63 ++++++
 rtl/md_sched.sv | 102 ++++++++++
 tb/tb_md_sched.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/md_defs.sv
// md_defs: shared encodings for the multiply/divide scheduler.
// Op codes, FSM states and default latencies.
package md_defs;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_MFHI  = 3'd6,
      MD_MFLO  = 3'd7
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   // Codes 0..3 are the ops that occupy the busy window
   function automatic logic md_is_long(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic md_is_mul(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/md_sched_if.sv
// md_sched_if: E-stage side of the multiply/divide scheduler.
// master = pipeline driving ops, slave = md_sched.
interface md_sched_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       md_op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             md_instr_D;
   logic             busy;
   logic             stall_md;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] md_rdata;

   modport master (
      output start, md_op, rs_val, rt_val, md_instr_D,
      input  busy, stall_md, hi, lo, md_rdata
   );

   modport slave (
      input  start, md_op, rs_val, rt_val, md_instr_D,
      output busy, stall_md, hi, lo, md_rdata
   );
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational product / quotient / remainder.
// Signed divide runs on magnitudes so MIN/-1 wraps cleanly.
module md_arith
   import md_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div_zero
);

   logic             sgn;
   logic [2*WIDTH-1:0] ea;
   logic [2*WIDTH-1:0] eb;
   logic [2*WIDTH-1:0] prod;
   logic             neg_a;
   logic             neg_b;
   logic [WIDTH-1:0] ua;
   logic [WIDTH-1:0] ub;
   logic [WIDTH-1:0] ub_safe;
   logic [WIDTH-1:0] uq;
   logic [WIDTH-1:0] ur;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;

   assign sgn = (op == MD_MULT) || (op == MD_DIV);

   // Low 2W bits of an extended product are correct for both signs
   assign ea   = sgn ? {{WIDTH{a[WIDTH-1]}}, a}
                     : {{WIDTH{1'b0}}, a};
   assign eb   = sgn ? {{WIDTH{b[WIDTH-1]}}, b}
                     : {{WIDTH{1'b0}}, b};
   assign prod = ea * eb;

   assign neg_a   = sgn & a[WIDTH-1];
   assign neg_b   = sgn & b[WIDTH-1];
   assign ua      = neg_a ? ('0 - a) : a;
   assign ub      = neg_b ? ('0 - b) : b;
   assign ub_safe = (ub == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
   assign uq      = ua / ub_safe;
   assign ur      = ua % ub_safe;
   assign q       = (neg_a ^ neg_b) ? ('0 - uq) : uq;
   assign r       = neg_a ? ('0 - ur) : ur;

   assign div_zero = (b == '0);

   always_comb begin
      res_hi = '0;
      res_lo = '0;
      if (md_is_mul(op)) begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (md_is_long(op)) begin
         res_hi = r;
         res_lo = q;
      end
   end

endmodule

// File: rtl/md_sched.sv
// md_sched: owns HI/LO and the fixed-latency mult/div busy window.
// Result is computed at issue and committed when the window closes.
module md_sched
   import md_defs::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input logic        clk,
   input logic        reset,
   md_sched_if.slave  bus
);

   localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   md_state_e        state;
   md_state_e        state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] pend_hi;
   logic [WIDTH-1:0] pend_lo;
   logic             pend_dz;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             div_zero;
   logic             long_op;
   logic             take;
   logic             last;
   logic             idle;

   md_arith #(.WIDTH(WIDTH)) u_arith (
      .op       (bus.md_op),
      .a        (bus.rs_val),
      .b        (bus.rt_val),
      .res_hi   (res_hi),
      .res_lo   (res_lo),
      .div_zero (div_zero)
   );

   assign long_op = md_is_long(bus.md_op);
   assign idle    = (state == MD_IDLE);
   assign take    = idle & bus.start & long_op;
   assign last    = (state == MD_RUN) && (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (!reset) state <= MD_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         MD_IDLE: if (take) state_nx = MD_RUN;
         MD_RUN:  if (last) state_nx = MD_IDLE;
         default: state_nx = MD_IDLE;
      endcase
   end

   always_comb begin
      bus.busy     = (state == MD_RUN);
      bus.stall_md = bus.md_instr_D &
                     (bus.busy | (bus.start & long_op));
      bus.hi       = hi_q;
      bus.lo       = lo_q;
      bus.md_rdata = (bus.md_op == MD_MFHI) ? hi_q : lo_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_dz <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         if (take) begin
            cnt     <= md_is_mul(bus.md_op) ?
                       CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_dz <= div_zero & ~md_is_mul(bus.md_op);
         end else if (state == MD_RUN) begin
            cnt <= cnt - CW'(1);
         end
         // Divide by zero still burns the window but leaves HI/LO alone
         if (last && !pend_dz) begin
            hi_q <= pend_hi;
            lo_q <= pend_lo;
         end
         if (idle && bus.start && bus.md_op == MD_MTHI)
            hi_q <= bus.rs_val;
         if (idle && bus.start && bus.md_op == MD_MTLO)
            lo_q <= bus.rs_val;
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and random checks of md_sched against
// an arithmetic reference of HI/LO and the busy/stall timing.
module tb_md_sched;
   import md_defs::*;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic [31:0] mhi;
   logic [31:0] mlo;

   md_sched_if #(.WIDTH(32)) bus ();

   md_sched #(
      .WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void ref_md(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  inout logic [31:0] h,
                                  inout logic [31:0] l);
      longint sp;
      longint unsigned up;
      longint sq;
      longint sr;
      case (op)
         MD_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            h  = sp[63:32];
            l  = sp[31:0];
         end
         MD_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            h  = up[63:32];
            l  = up[31:0];
         end
         MD_DIV: if (b != 0) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            h  = sr[31:0];
            l  = sq[31:0];
         end
         MD_DIVU: if (b != 0) begin
            h = a % b;
            l = a / b;
         end
         default: ;
      endcase
   endfunction

   task automatic do_long(input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
      int n;
      logic [31:0] eh;
      logic [31:0] el;
      n  = md_is_mul(op) ? 5 : 10;
      eh = mhi;
      el = mlo;
      ref_md(op, a, b, eh, el);
      bus.start      = 1'b1;
      bus.md_op      = op;
      bus.rs_val     = a;
      bus.rt_val     = b;
      bus.md_instr_D = 1'b1;
      #1;
      chk("issue_stall", {31'd0, bus.stall_md}, 32'd1);
      chk("issue_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         chk("run_busy", {31'd0, bus.busy}, 32'd1);
         chk("run_stall", {31'd0, bus.stall_md}, 32'd1);
         chk("run_hi_hold", bus.hi, mhi);
         @(negedge clk);
      end
      chk("done_busy", {31'd0, bus.busy}, 32'd0);
      chk("done_stall", {31'd0, bus.stall_md}, 32'd0);
      chk("done_hi", bus.hi, eh);
      chk("done_lo", bus.lo, el);
      mhi = eh;
      mlo = el;
      bus.md_instr_D = 1'b0;
   endtask

   task automatic do_mt(input logic [2:0] op,
                        input logic [31:0] a);
      bus.start  = 1'b1;
      bus.md_op  = op;
      bus.rs_val = a;
      bus.rt_val = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
      if (op == MD_MTHI) mhi = a;
      else               mlo = a;
      chk("mt_busy", {31'd0, bus.busy}, 32'd0);
      chk("mt_hi", bus.hi, mhi);
      chk("mt_lo", bus.lo, mlo);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      checks         = 0;
      failures       = 0;
      mhi            = '0;
      mlo            = '0;
      reset          = 1'b0;
      bus.start      = 1'b0;
      bus.md_op      = MD_MFLO;
      bus.rs_val     = '0;
      bus.rt_val     = '0;
      bus.md_instr_D = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall_md}, 32'd0);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      reset = 1'b1;
      bus.md_instr_D = 1'b0;

      do_mt(MD_MTHI, 32'h55);
      bus.start  = 1'b1;
      bus.md_op  = MD_MULT;
      bus.rs_val = 32'd3;
      bus.rt_val = 32'd4;
      @(negedge clk);
      bus.start = 1'b0;
      chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      mhi   = '0;
      mlo   = '0;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_hi", bus.hi, 32'd0);
      chk("midrst_lo", bus.lo, 32'd0);
      repeat (8) @(negedge clk);
      chk("nocommit_busy", {31'd0, bus.busy}, 32'd0);
      chk("nocommit_hi", bus.hi, 32'd0);
      chk("nocommit_lo", bus.lo, 32'd0);

      do_long(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
      chk("mult_hi_lit", bus.hi, 32'hFFFF_FFFF);
      chk("mult_lo_lit", bus.lo, 32'hFFFF_FFFE);
      do_long(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
      chk("multu_hi_lit", bus.hi, 32'h0000_0001);
      chk("multu_lo_lit", bus.lo, 32'hFFFF_FFFE);
      do_long(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      chk("div_lo_lit", bus.lo, 32'hFFFF_FFFD);
      chk("div_hi_lit", bus.hi, 32'hFFFF_FFFF);
      do_long(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("ovf_lo_lit", bus.lo, 32'h8000_0000);
      chk("ovf_hi_lit", bus.hi, 32'h0000_0000);

      do_mt(MD_MTHI, 32'h11);
      do_mt(MD_MTLO, 32'h22);
      do_long(MD_DIVU, 32'd5, 32'd0);
      chk("dz_hi_lit", bus.hi, 32'h11);
      chk("dz_lo_lit", bus.lo, 32'h22);

      do_mt(MD_MTHI, 32'hABCD);
      bus.md_op = MD_MFHI;
      #1;
      chk("mfhi_rdata", bus.md_rdata, 32'hABCD);
      bus.md_op = MD_MFLO;
      #1;
      chk("mflo_rdata", bus.md_rdata, 32'h22);
      bus.md_instr_D = 1'b1;
      #1;
      chk("idle_stall", {31'd0, bus.stall_md}, 32'd0);
      bus.start = 1'b1;
      bus.md_op = MD_MFHI;
      @(negedge clk);
      bus.start = 1'b0;
      chk("mf_start_busy", {31'd0, bus.busy}, 32'd0);
      chk("mf_start_hi", bus.hi, 32'hABCD);
      bus.md_instr_D = 1'b0;

      for (int k = 0; k < 24; k++) begin
         op = 3'($urandom_range(0, 5));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 5) == 0) b = '0;
         if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(1, 9));
         if (md_is_long(op)) do_long(op, a, b);
         else                do_mt(op, a);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
